icache_refill_responder: RTL and testbench

Memory-side responder for the instruction cache's block refill interface. Accepts one 64-byte block request at a time, waits a programmable access latency, then streams the block back as 16 little-endian 32-bit words with valid/ready flow control. Holds the byte-addressed instruction memory image and provides a byte load port for program preload while idle.

---
 rtl/icache_refill_responder_if.sv | 34 +++
 rtl/icache_refill_responder.sv | 112 +++++++++++
 tb/tb_icache_refill_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_responder_if.sv
// Refill request/response channel between the instruction cache and
// the memory-side responder.
interface icache_refill_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [3:0]  resp_word;
  logic        resp_last;

  modport master (
    output req_valid,
    output req_address,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_word,
    input  resp_last
  );

  modport slave (
    input  req_valid,
    input  req_address,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_word,
    output resp_last
  );
endinterface

// File: rtl/icache_refill_responder.sv
// Instruction memory that answers cache refills: one 64-byte block per
// request, streamed as 16 words after a fixed access latency.
module icache_refill_responder #(
  parameter int MEM_BYTES = 65536,
  parameter int LATENCY   = 4
) (
  input  logic        clock,
  input  logic        reset,
  icache_refill_responder_if.slave bus,
  output logic        busy,
  input  logic        load_en,
  input  logic [31:0] load_address,
  input  logic [7:0]  load_byte
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;

  // A zero latency still needs one cycle to fetch beat 0 into the
  // output register, so it behaves like a latency of one.
  localparam logic [3:0] WAIT_INIT =
    (LATENCY == 0) ? 4'd1 : 4'(LATENCY);

  logic [7:0]    mem [MEM_BYTES];
  logic [1:0]    state;
  logic [1:0]    state_d;
  logic [3:0]    wait_cnt;
  logic [AW-1:0] base;
  logic [AW-1:0] req_base;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_word;
  logic [31:0]   rd_data;
  logic          accept;
  logic          beat_done;
  logic          unused_bits;

  assign unused_bits = ^{bus.req_address, load_address};

  assign req_base  = {bus.req_address[AW-1:6], 6'b0};
  assign accept    = (state == IDLE) && bus.req_valid;
  assign beat_done = (state == STREAM) && bus.resp_ready;

  // Next word to present: beat 0 while waiting, then word + 1.
  assign rd_word = (state == STREAM) ?
                   bus.resp_word + 4'd1 : 4'd0;
  assign rd_addr = base + AW'({rd_word, 2'b00});

  for (genvar i = 0; i < 4; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr + AW'(i);
    assign rd_data[8*i +: 8] = mem[a];
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:
        if (bus.req_valid) state_d = WAIT;
      WAIT:
        if (wait_cnt == 4'd1) state_d = STREAM;
      STREAM:
        if (beat_done && bus.resp_last) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (load_en && state == IDLE)
      mem[load_address[AW-1:0]] <= load_byte;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      base           <= '0;
      busy           <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_data  <= '0;
      bus.resp_word  <= '0;
      bus.resp_last  <= 1'b0;
    end else begin
      state          <= state_d;
      busy           <= (state_d != IDLE);
      bus.req_ready  <= (state_d == IDLE);
      bus.resp_valid <= (state_d == STREAM);
      if (accept) begin
        base          <= req_base;
        wait_cnt      <= WAIT_INIT;
        bus.resp_word <= '0;
        bus.resp_last <= 1'b0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          bus.resp_data <= rd_data;
          bus.resp_word <= '0;
          bus.resp_last <= 1'b0;
        end
      end
      if (beat_done) begin
        bus.resp_data <= rd_data;
        bus.resp_word <= rd_word;
        bus.resp_last <= (rd_word == 4'd15);
      end
    end
  end
endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: two instances (latency 4 and 0)
// checked against a byte-array model of the instruction image.
module tb_icache_refill_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rv, rr, le;
  logic [1:0]  ov, ol, rq, bz;
  logic [31:0] ra [2];
  logic [31:0] la [2];
  logic [7:0]  lb [2];
  logic [31:0] od [2];
  logic [3:0]  ow [2];

  logic [7:0]  mm [2][65536];
  logic [31:0] cap [16];
  int          got_lat;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  icache_refill_responder_if b0 ();
  icache_refill_responder_if b1 ();

  assign b0.req_valid   = rv[0];
  assign b0.req_address = ra[0];
  assign b0.resp_ready  = rr[0];
  assign b1.req_valid   = rv[1];
  assign b1.req_address = ra[1];
  assign b1.resp_ready  = rr[1];
  assign ov[0] = b0.resp_valid;
  assign ol[0] = b0.resp_last;
  assign rq[0] = b0.req_ready;
  assign od[0] = b0.resp_data;
  assign ow[0] = b0.resp_word;
  assign ov[1] = b1.resp_valid;
  assign ol[1] = b1.resp_last;
  assign rq[1] = b1.req_ready;
  assign od[1] = b1.resp_data;
  assign ow[1] = b1.resp_word;

  icache_refill_responder #(.MEM_BYTES(65536), .LATENCY(4)) dut_l4 (
    .clock(clk), .reset(rst_n), .bus(b0), .busy(bz[0]),
    .load_en(le[0]), .load_address(la[0]), .load_byte(lb[0])
  );

  icache_refill_responder #(.MEM_BYTES(65536), .LATENCY(0)) dut_l0 (
    .clock(clk), .reset(rst_n), .bus(b1), .busy(bz[1]),
    .load_en(le[1]), .load_address(la[1]), .load_byte(lb[1])
  );

  typedef struct {
    int          d;
    logic [31:0] addr;
    int          mode;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w15;
    int          lat;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mword(input int d, input int base,
                                        input int w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = mm[d][(base + 4*w + i) % 65536];
    return r;
  endfunction

  task automatic load(input int d, input logic [31:0] a,
                      input logic [7:0] v);
    le[d] = 1'b1;
    la[d] = a;
    lb[d] = v;
    @(posedge clk);
    @(negedge clk);
    le[d] = 1'b0;
    mm[d][a[15:0]] = v;
  endtask

  task automatic request(input int d, input logic [31:0] addr,
                         input bit hold);
    chk("req_ready_idle", rq[d], 1);
    rv[d] = 1'b1;
    ra[d] = addr;
    @(posedge clk);
    @(negedge clk);
    if (!hold) rv[d] = 1'b0;
  endtask

  // Entered at the falling edge right after the accepting rising edge.
  task automatic stream(input int d, input int base, input int mode,
                        input int inj, input int rst_at);
    int w, k, guard;
    bit take;
    w = 0; k = 0; guard = 0; got_lat = -1;
    chk("busy_after_accept", bz[d], 1);
    chk("req_ready_after_accept", rq[d], 0);
    while (!ov[d] && k < 40) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    if (!ov[d]) begin
      chk("first_valid_timeout", 0, 1);
      return;
    end
    got_lat = k;
    while (w < 16 && guard < 300) begin
      chk("resp_valid", ov[d], 1);
      chk("req_ready_busy", rq[d], 0);
      chk("resp_word", ow[d], w);
      chk("resp_data", od[d], mword(d, base, w));
      chk("resp_last", ol[d], (w == 15));
      cap[w] = od[d];
      if (w == rst_at) begin
        rr[d] = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", ov[d], 0);
        chk("rst_req_ready", rq[d], 1);
        chk("rst_busy", bz[d], 0);
        chk("rst_word", ow[d], 0);
        chk("rst_data", od[d], 0);
        chk("rst_last", ol[d], 0);
        repeat (3) begin
          @(negedge clk);
          chk("rst_hold_valid", ov[d], 0);
        end
        rst_n = 1'b1;
        repeat (6) begin
          @(negedge clk);
          chk("post_rst_no_beat", ov[d], 0);
          chk("post_rst_idle", rq[d], 1);
        end
        return;
      end
      case (mode)
        1:       rr[d] = 1'b1;
        2:       rr[d] = (guard % 2 == 0);
        default: rr[d] = 1'($urandom_range(0, 1));
      endcase
      if (w == inj) begin
        le[d] = 1'b1;
        la[d] = base + 60;
        lb[d] = 8'hEE;
      end
      take = ov[d] && rr[d];
      @(posedge clk);
      @(negedge clk);
      le[d] = 1'b0;
      if (take) w++;
      guard++;
    end
    rr[d] = 1'b0;
    chk("beats_delivered", w, 16);
    chk("valid_after_last", ov[d], 0);
    chk("last_after_last", ol[d], 0);
    chk("req_ready_after_last", rq[d], 1);
    chk("busy_after_last", bz[d], 0);
  endtask

  task automatic run(input int d, input logic [31:0] addr, input int mode,
                     input int inj, input int rst_at);
    request(d, addr, 1'b0);
    stream(d, int'(addr[15:0]) & 32'hFFC0, mode, inj, rst_at);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, mode;
    logic [31:0] a;
    logic [7:0] pgm [8];

    tbl[0] = '{0, 32'h0000_0000, 1, 32'h0040_0093, 32'h00a0_0113,
               32'h3F3E_3D3C, 4};
    tbl[1] = '{0, 32'h0000_0027, 2, 32'h0040_0093, 32'h00a0_0113,
               32'h3F3E_3D3C, 4};
    tbl[2] = '{0, 32'h1234_008C, 3, 32'h8382_8180, 32'h8786_8584,
               32'hBFBE_BDBC, 4};
    tbl[3] = '{1, 32'h0000_FFFF, 1, 32'hC3C2_C1C0, 32'hC7C6_C5C4,
               32'hFFFE_FDFC, 1};
    tbl[4] = '{1, 32'h0001_0043, 3, 32'h4342_4140, 32'h4746_4544,
               32'h7F7E_7D7C, 1};
    pgm = '{8'h93, 8'h00, 8'h40, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00};

    rv = '0; rr = '0; le = '0;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; la[i] = '0; lb[i] = '0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_req_ready", rq[i], 1);
      chk("reset_resp_valid", ov[i], 0);
      chk("reset_resp_data", od[i], 0);
      chk("reset_resp_word", ow[i], 0);
      chk("reset_resp_last", ol[i], 0);
      chk("reset_busy", bz[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 256; i++) load(0, i, 8'(i));
    for (int i = 0; i < 8; i++) load(0, i, pgm[i]);
    for (int i = 0; i < 128; i++) load(1, i, 8'(i));
    for (int i = 32'hFFC0; i < 32'h10000; i++) load(1, i, 8'(i));

    foreach (tbl[i]) begin
      run(tbl[i].d, tbl[i].addr, tbl[i].mode, -1, -1);
      chk("tbl_latency", got_lat, tbl[i].lat);
      chk("tbl_word0", cap[0], tbl[i].w0);
      chk("tbl_word1", cap[1], tbl[i].w1);
      chk("tbl_word15", cap[15], tbl[i].w15);
    end

    run(0, 32'h80, 1, 3, -1);
    chk("stream_load_ignored", cap[15], 32'hBFBE_BDBC);
    load(0, 32'hBC, 8'hEE);
    run(0, 32'h80, 1, -1, -1);
    chk("idle_load_applied", cap[15], 32'hBFBE_BDEE);

    run(0, 32'h0, 1, -1, 7);
    run(0, 32'h40, 1, -1, -1);
    chk("after_reset_latency", got_lat, 4);
    chk("after_reset_word0", cap[0], 32'h4342_4140);
    chk("after_reset_word15", cap[15], 32'h7F7E_7D7C);

    request(0, 32'h0, 1'b1);
    stream(0, 0, 1, -1, -1);
    @(posedge clk);
    @(negedge clk);
    rv[0] = 1'b0;
    stream(0, 0, 2, -1, -1);
    chk("held_req_word0", cap[0], 32'h0040_0093);
    repeat (3) begin
      @(negedge clk);
      chk("no_third_accept", bz[0], 0);
    end

    le[1] = 1'b1;
    la[1] = 32'h44;
    lb[1] = 8'h77;
    request(1, 32'h44, 1'b0);
    le[1] = 1'b0;
    mm[1][16'h44] = 8'h77;
    stream(1, 32'h40, 1, -1, -1);
    chk("coincident_load", cap[1], 32'h4746_4577);

    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) begin
        if (d == 0)
          a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 255));
        else if ($urandom_range(0, 1) == 0)
          a = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 127));
        else
          a = $urandom | 32'h0000_FFC0;
        load(d, a, 8'($urandom));
      end
      if (d == 0)
        a = $urandom & 32'hFFFF_00FF;
      else if ($urandom_range(0, 1) == 0)
        a = $urandom & 32'hFFFF_007F;
      else
        a = $urandom | 32'h0000_FFC0;
      mode = $urandom_range(1, 3);
      run(d, a, mode, -1, -1);
      chk("rand_latency", got_lat, (d == 0) ? 4 : 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
